// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared definitions for the CORDIC control path: controller
//               state encoding, datapath variable selects, angle-region codes
//               and the output-select helper.
// Revision    : 1.0 - successor controller (v3) with watchdog and
//               parameterised iteration count
// ============================================================================
package cordic_pkg;

    // Controller states. The width is fixed explicitly so that the state
    // register width does not depend on how many states are listed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PREP   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_STORE  = 3'd5,
        ST_OUTPUT = 3'd6,
        ST_DONE   = 3'd7
    } cordic_state_t;

    // Datapath variable being updated by the shared add/subtract unit.
    localparam logic [1:0] VAR_X = 2'd0;
    localparam logic [1:0] VAR_Y = 2'd1;
    localparam logic [1:0] VAR_Z = 2'd2;

    // Angle-region flag encodings.
    localparam logic [1:0] REGION_00 = 2'b00;
    localparam logic [1:0] REGION_01 = 2'b01;
    localparam logic [1:0] REGION_10 = 2'b10;
    localparam logic [1:0] REGION_11 = 2'b11;

    // Output register select: the requested function (0 = cos -> X,
    // 1 = sin -> Y) is swapped when the angle was folded from region 01 or 10,
    // because folding by a quarter turn exchanges the roles of X and Y.
    function automatic logic out_select(input logic op, input logic [1:0] region);
        logic w_swap;
        w_swap = (region == REGION_01) || (region == REGION_10);
        return op ^ w_swap;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_iter_counter
// Description : Parameterised up-counter with synchronous load, count enable
//               and a terminal-count flag. Used as the CORDIC iteration index.
// Ports       : clk          - system clock
//               reset        - asynchronous active-low reset (count -> 0)
//               i_load       - load i_load_value (has priority over enable)
//               i_load_value - value loaded when i_load is high
//               i_enable     - increment by one
//               o_count      - current count
//               o_max_tick   - high while o_count equals MAX_VALUE
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_counter #(
    parameter int WIDTH     = 5,
    parameter int MAX_VALUE = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_max_tick
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_max_tick = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/cordic_fsm_v3.sv
`default_nettype none
// ============================================================================
// Module      : cordic_fsm_v3
// Description : Control FSM for an iterative CORDIC core sharing a single
//               floating-point add/subtract unit. Each micro-rotation updates
//               X, Y and Z in turn through the shared unit. A watchdog on the
//               add/subtract handshake ends the operation with an error
//               instead of stalling when the unit never answers.
// Ports       : clk, reset (async, active-low)
//               beg_FSM_CORDIC / ACK_FSM_CORDIC  - start request / result taken
//               operation, mode_in, shift_region_flag - latched at start
//               ready_add_subt                   - add/subtract result valid
//               beg_add_subt / ack_add_subt      - add/subtract handshake
//               reset_reg_cordic                 - clear datapath registers
//               ready_CORDIC / error_CORDIC      - result (or error) available
//               sel_mux_1/2/3, mode, iter_count  - datapath selects
//               enab_*                           - one-cycle register enables
// Revision    : 3.0 - internal counters, parameterised iterations,
//               per-operation mode, add/subtract watchdog
// ============================================================================
module cordic_fsm_v3
    import cordic_pkg::*;
#(
    parameter int ITERATIONS  = 24,
    parameter int ITER_W      = 5,
    parameter int ADD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beg_FSM_CORDIC,
    input  logic              ACK_FSM_CORDIC,
    input  logic              operation,
    input  logic              mode_in,
    input  logic [1:0]        shift_region_flag,
    input  logic              ready_add_subt,
    output logic              reset_reg_cordic,
    output logic              ready_CORDIC,
    output logic              error_CORDIC,
    output logic              beg_add_subt,
    output logic              ack_add_subt,
    output logic              sel_mux_1,
    output logic [1:0]        sel_mux_2,
    output logic              sel_mux_3,
    output logic              mode,
    output logic [ITER_W-1:0] iter_count,
    output logic              enab_RB1,
    output logic              enab_RB2,
    output logic              enab_d_ff_Xn,
    output logic              enab_d_ff_Yn,
    output logic              enab_d_ff_Zn,
    output logic              enab_dff_shifted_x,
    output logic              enab_dff_shifted_y,
    output logic              enab_dff_LUT,
    output logic              enab_dff_sign,
    output logic              enab_d_ff_out
);

    // The watchdog counts completed WAIT cycles 0 .. ADD_TIMEOUT-1.
    localparam int c_WD_W = (ADD_TIMEOUT > 1) ? $clog2(ADD_TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(ADD_TIMEOUT - 1);

    cordic_state_t     r_state;
    cordic_state_t     w_next_state;

    logic [1:0]        r_var;
    logic [c_WD_W-1:0] r_wd;
    logic              r_error;
    logic              r_operation;
    logic              r_mode;
    logic [1:0]        r_region;

    logic [ITER_W-1:0] w_iter_count;
    logic              w_iter_last;
    logic              w_iter_load;
    logic              w_iter_enable;
    logic              w_timeout;
    logic              w_done_exit;

    assign w_timeout   = (r_wd == c_WD_LAST);
    assign w_done_exit = (r_state == ST_DONE) && ACK_FSM_CORDIC;

    // ------------------------------------------------------------------------
    // Iteration counter. Cleared at the start of an operation and again on
    // the return to IDLE so that iter_count reads 0 while idle.
    // ------------------------------------------------------------------------
    assign w_iter_load   = (r_state == ST_LOAD) || w_done_exit;
    assign w_iter_enable = (r_state == ST_STORE) && (r_var == VAR_Z) && !w_iter_last;

    cordic_iter_counter #(
        .WIDTH     (ITER_W),
        .MAX_VALUE (ITERATIONS - 1)
    ) u_iter_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_iter_load),
        .i_load_value ({ITER_W{1'b0}}),
        .i_enable     (w_iter_enable),
        .o_count      (w_iter_count),
        .o_max_tick   (w_iter_last)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Variable index, watchdog, error flag and fields latched at start.
    // The latched fields are dropped on the way back to IDLE so that every
    // output reads 0 while the controller is idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_var       <= VAR_X;
            r_wd        <= '0;
            r_error     <= 1'b0;
            r_operation <= 1'b0;
            r_mode      <= 1'b0;
            r_region    <= REGION_00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (beg_FSM_CORDIC) begin
                        r_operation <= operation;
                        r_mode      <= mode_in;
                        r_region    <= shift_region_flag;
                    end
                end
                ST_LOAD: begin
                    r_var   <= VAR_X;
                    r_error <= 1'b0;
                end
                ST_ISSUE: begin
                    r_wd <= '0;
                end
                ST_WAIT: begin
                    // A ready in the same cycle as the last allowed WAIT
                    // cycle still counts as a successful handshake.
                    if (!ready_add_subt) begin
                        if (w_timeout) begin
                            r_error <= 1'b1;
                        end else begin
                            r_wd <= r_wd + c_WD_W'(1);
                        end
                    end
                end
                ST_STORE: begin
                    r_var <= (r_var == VAR_Z) ? VAR_X : (r_var + 2'd1);
                end
                ST_DONE: begin
                    if (ACK_FSM_CORDIC) begin
                        r_error     <= 1'b0;
                        r_operation <= 1'b0;
                        r_mode      <= 1'b0;
                        r_region    <= REGION_00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and per-state outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state       = r_state;
        reset_reg_cordic   = 1'b0;
        ready_CORDIC       = 1'b0;
        beg_add_subt       = 1'b0;
        ack_add_subt       = 1'b0;
        sel_mux_2          = VAR_X;
        enab_RB1           = 1'b0;
        enab_RB2           = 1'b0;
        enab_d_ff_Xn       = 1'b0;
        enab_d_ff_Yn       = 1'b0;
        enab_d_ff_Zn       = 1'b0;
        enab_dff_shifted_x = 1'b0;
        enab_dff_shifted_y = 1'b0;
        enab_dff_LUT       = 1'b0;
        enab_dff_sign      = 1'b0;
        enab_d_ff_out      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (beg_FSM_CORDIC) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                reset_reg_cordic = 1'b1;
                enab_RB1         = 1'b1;
                w_next_state     = ST_PREP;
            end
            ST_PREP: begin
                // Capture shifted operands, arctangent LUT entry and rotation
                // direction for the current micro-rotation.
                enab_RB2           = 1'b1;
                enab_dff_shifted_x = 1'b1;
                enab_dff_shifted_y = 1'b1;
                enab_dff_LUT       = 1'b1;
                enab_dff_sign      = 1'b1;
                w_next_state       = ST_ISSUE;
            end
            ST_ISSUE: begin
                sel_mux_2    = r_var;
                beg_add_subt = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                sel_mux_2 = r_var;
                if (ready_add_subt) begin
                    w_next_state = ST_STORE;
                end else if (w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_STORE: begin
                sel_mux_2    = r_var;
                ack_add_subt = 1'b1;
                case (r_var)
                    VAR_X:   enab_d_ff_Xn = 1'b1;
                    VAR_Y:   enab_d_ff_Yn = 1'b1;
                    VAR_Z:   enab_d_ff_Zn = 1'b1;
                    default: begin
                    end
                endcase
                if (r_var != VAR_Z) begin
                    w_next_state = ST_ISSUE;
                end else if (w_iter_last) begin
                    w_next_state = ST_OUTPUT;
                end else begin
                    w_next_state = ST_PREP;
                end
            end
            ST_OUTPUT: begin
                enab_d_ff_out = 1'b1;
                w_next_state  = ST_DONE;
            end
            ST_DONE: begin
                ready_CORDIC = 1'b1;
                if (ACK_FSM_CORDIC) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs derived from registered state
    // ------------------------------------------------------------------------
    assign iter_count   = w_iter_count;
    assign sel_mux_1    = |w_iter_count;
    assign sel_mux_3    = out_select(r_operation, r_region);
    assign mode         = r_mode;
    assign error_CORDIC = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cordic_fsm_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_fsm_v3
// Description : Self-checking bench for cordic_fsm_v3. An add/subtract
//               responder answers each request after a random number of WAIT
//               cycles (or never, to provoke the watchdog). Expected latency,
//               request count, selects and flags come from the timing rules
//               of the controller evaluated with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_fsm_v3;

    localparam int ITER = 4;
    localparam int IW   = 3;
    localparam int TMO  = 8;
    localparam int NADD = 3 * ITER;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          beg_FSM_CORDIC = 1'b0;
    logic          ACK_FSM_CORDIC = 1'b0;
    logic          operation = 1'b0;
    logic          mode_in = 1'b0;
    logic [1:0]    shift_region_flag = 2'b00;
    logic          ready_add_subt = 1'b0;

    logic          reset_reg_cordic, ready_CORDIC, error_CORDIC;
    logic          beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3, mode;
    logic [1:0]    sel_mux_2;
    logic [IW-1:0] iter_count;
    logic          enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
    logic          enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT;
    logic          enab_dff_sign, enab_d_ff_out;

    logic [22:0]   outs;

    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    cordic_fsm_v3 #(
        .ITERATIONS  (ITER),
        .ITER_W      (IW),
        .ADD_TIMEOUT (TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .beg_FSM_CORDIC     (beg_FSM_CORDIC),
        .ACK_FSM_CORDIC     (ACK_FSM_CORDIC),
        .operation          (operation),
        .mode_in            (mode_in),
        .shift_region_flag  (shift_region_flag),
        .ready_add_subt     (ready_add_subt),
        .reset_reg_cordic   (reset_reg_cordic),
        .ready_CORDIC       (ready_CORDIC),
        .error_CORDIC       (error_CORDIC),
        .beg_add_subt       (beg_add_subt),
        .ack_add_subt       (ack_add_subt),
        .sel_mux_1          (sel_mux_1),
        .sel_mux_2          (sel_mux_2),
        .sel_mux_3          (sel_mux_3),
        .mode               (mode),
        .iter_count         (iter_count),
        .enab_RB1           (enab_RB1),
        .enab_RB2           (enab_RB2),
        .enab_d_ff_Xn       (enab_d_ff_Xn),
        .enab_d_ff_Yn       (enab_d_ff_Yn),
        .enab_d_ff_Zn       (enab_d_ff_Zn),
        .enab_dff_shifted_x (enab_dff_shifted_x),
        .enab_dff_shifted_y (enab_dff_shifted_y),
        .enab_dff_LUT       (enab_dff_LUT),
        .enab_dff_sign      (enab_dff_sign),
        .enab_d_ff_out      (enab_d_ff_out)
    );

    assign outs = {reset_reg_cordic, ready_CORDIC, error_CORDIC, beg_add_subt,
                   ack_add_subt, sel_mux_1, sel_mux_2, sel_mux_3, mode, iter_count,
                   enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn,
                   enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT,
                   enab_dff_sign, enab_d_ff_out};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One complete operation.
    //   fixed_lat : WAIT cycles per addition (0 = random 1..4)
    //   hang_k    : index of the addition that never gets ready (-1 = none)
    //   abort_k   : drop reset in the first WAIT cycle of this addition (-1 = none)
    //   ack_dly   : DONE cycles before ACK is raised
    //   ack_hold  : ACK held high for the whole operation
    task automatic run_op(input logic op, input logic md, input logic [1:0] rg,
                          input int fixed_lat, input int hang_k, input int abort_k,
                          input int ack_dly, input logic ack_hold);
        int   lat [NADD];
        int   cum, exp_cyc, exp_beg, exp_iter;
        int   cyc, k_issue, k_ack, wait_cnt, d;
        logic pend, got_ready, exp_sel3;

        for (int k = 0; k < NADD; k++)
            lat[k] = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));

        // Reference: LOAD, then per iteration one PREP plus three additions
        // of (ISSUE + L WAIT + STORE), then OUTPUT, then DONE. A hung addition
        // leaves after TMO WAIT cycles straight to DONE.
        exp_sel3 = op ^ ((rg == 2'b01) || (rg == 2'b10));
        cum = 0;
        if (hang_k >= 0) begin
            for (int k = 0; k < hang_k; k++) cum += 2 + lat[k];
            exp_cyc  = 2 + (hang_k / 3 + 1) + cum + 1 + TMO;
            exp_beg  = hang_k + 1;
            exp_iter = hang_k / 3;
        end else begin
            for (int k = 0; k < NADD; k++) cum += 2 + lat[k];
            exp_cyc  = 3 + ITER + cum;
            exp_beg  = NADD;
            exp_iter = ITER - 1;
        end

        @(negedge clk);
        beg_FSM_CORDIC    = 1'b1;
        operation         = op;
        mode_in           = md;
        shift_region_flag = rg;
        ACK_FSM_CORDIC    = ack_hold;
        ready_add_subt    = 1'b0;
        cyc = 0; k_issue = 0; k_ack = 0; wait_cnt = 0;
        pend = 1'b0; got_ready = 1'b0;

        while (!got_ready && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ready_CORDIC) begin
                got_ready = 1'b1;
            end else begin
                // Inputs that must be ignored outside IDLE / DONE.
                beg_FSM_CORDIC    = ($urandom_range(0, 3) == 0);
                operation         = 1'($urandom);
                mode_in           = 1'($urandom);
                shift_region_flag = 2'($urandom);
                ACK_FSM_CORDIC    = ack_hold | 1'($urandom);

                if (cyc == 1)
                    check_val("load_enables", {reset_reg_cordic, enab_RB1}, 2'b11);
                if (cyc == 2)
                    check_val("prep_enables", {enab_RB2, enab_dff_shifted_x, enab_dff_shifted_y,
                                               enab_dff_LUT, enab_dff_sign}, 5'h1F);

                ready_add_subt = 1'b0;
                if (pend) begin
                    wait_cnt++;
                    if (abort_k >= 0 && (k_issue - 1) == abort_k) begin
                        reset = 1'b0;
                        #1;
                        check_val("reset_outputs", outs, 0);
                        @(negedge clk);
                        beg_FSM_CORDIC = 1'b0;
                        ACK_FSM_CORDIC = 1'b0;
                        reset = 1'b1;
                        return;
                    end
                    if (wait_cnt == lat[k_issue - 1] && (k_issue - 1) != hang_k) begin
                        ready_add_subt = 1'b1;
                        pend = 1'b0;
                    end
                end
                if (beg_add_subt) begin
                    check_val("issue_var", sel_mux_2, k_issue % 3);
                    check_val("issue_iter", iter_count, k_issue / 3);
                    check_val("issue_sel1", sel_mux_1, (k_issue / 3) != 0);
                    check_val("issue_mode", mode, md);
                    check_val("issue_sel3", sel_mux_3, exp_sel3);
                    pend = 1'b1;
                    wait_cnt = 0;
                    // A ready during ISSUE must not complete the addition.
                    ready_add_subt = 1'($urandom);
                    k_issue++;
                end
                if (ack_add_subt) begin
                    check_val("store_enable", {enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn},
                              3'b100 >> (k_ack % 3));
                    k_ack++;
                end
            end
        end

        if (!got_ready) begin
            check_val("ready_timeout", 0, 1);
            beg_FSM_CORDIC = 1'b0;
            ACK_FSM_CORDIC = 1'b0;
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            return;
        end

        check_val("latency", cyc, exp_cyc);
        check_val("error_flag", error_CORDIC, hang_k >= 0);
        check_val("add_pulses", k_issue, exp_beg);
        check_val("done_iter", iter_count, exp_iter);
        check_val("done_sel3", sel_mux_3, exp_sel3);
        check_val("done_mode", mode, md);

        d = 0;
        while (ready_CORDIC && d < 20) begin
            ACK_FSM_CORDIC = ack_hold || (d >= ack_dly);
            beg_FSM_CORDIC = 1'($urandom);
            @(negedge clk);
            d++;
        end
        beg_FSM_CORDIC = 1'b0;
        check_val("ready_cycles", d, ack_hold ? 1 : ack_dly + 1);
        check_val("idle_outputs", outs, 0);
        @(negedge clk);
        ACK_FSM_CORDIC = 1'b0;
        check_val("idle_stays", outs, 0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_state", outs, 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_after_reset", outs, 0);

        // L = 2 everywhere: 2 + 4*13 + 1 = 55 cycles, 12 requests, sel_mux_3 = 0.
        run_op(1'b0, 1'b0, 2'b00, 2, -1, -1, 0, 1'b0);
        // Region 01 swaps sine onto X; region 11 keeps it on Y.
        run_op(1'b1, 1'b0, 2'b01, 0, -1, -1, 1, 1'b0);
        run_op(1'b1, 1'b1, 2'b11, 0, -1, -1, 0, 1'b1);
        // Watchdog on the very first request and on one mid-run.
        run_op(1'b0, 1'b1, 2'b10, 1, 0, -1, 2, 1'b0);
        run_op(1'b1, 1'b0, 2'b00, 0, 7, -1, 0, 1'b0);
        // Reset during WAIT of iteration 2, then a fresh operation.
        run_op(1'b1, 1'b1, 2'b01, 0, -1, 6, 0, 1'b0);
        run_op(1'b0, 1'b0, 2'b11, 0, -1, -1, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_op(1'($urandom), 1'($urandom), 2'($urandom), 0,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NADD - 1)) : -1,
                   -1, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
